csr_timer_intc: RTL and testbench

- Timer and interrupt controller for the CSR file.
- Owns the TCFG/TVAL countdown timer and the TI pending bit.
- Synchronises hardware and IPI interrupt lines and assembles ESTAT.IS[12:0].
- Masks ESTAT.IS with ECFG.LIE and CRMD.IE, then presents one interrupt request to the commit stage through a req/ack handshake. Commit then drives the CSR file's exception entry with ecode 0.

---
 rtl/csr_timer_intc_pkg.sv | 35 +++
 rtl/csr_int_sync.sv | 38 +++
 rtl/csr_timer_intc.sv | 161 ++++++++++++++++
 tb/tb_csr_timer_intc.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_timer_intc_pkg.sv
// Shared field positions, state encodings and helpers for the CSR timer
// and interrupt controller.
package csr_timer_intc_pkg;

    // TCFG register fields
    localparam int TCFG_EN          = 0;
    localparam int TCFG_PERIODIC    = 1;
    localparam int TCFG_INITVAL_LSB = 2;
    localparam int TCFG_INITVAL_MSB = 31;

    // TICLR register fields
    localparam int TICLR_CLR = 0;

    // ESTAT.IS bit positions
    localparam int ESTAT_IS_W        = 13;
    localparam int ESTAT_IS_SOFT_LSB = 0;
    localparam int ESTAT_IS_SOFT_MSB = 1;
    localparam int ESTAT_IS_HARD_LSB = 2;
    localparam int ESTAT_IS_HARD_MSB = 9;
    localparam int ESTAT_IS_TI       = 11;
    localparam int ESTAT_IS_IPI      = 12;

    // Interrupt request handshake states
    typedef enum logic [1:0] {
        INT_IDLE = 2'd0,
        INT_REQ  = 2'd1,
        INT_HOLD = 2'd2
    } int_state_e;

    // Reload value for TVAL: InitVal scaled by 4 (low two bits forced to 0)
    function automatic logic [31:0] tcfg_reload(input logic [31:0] cfg);
        return {cfg[TCFG_INITVAL_MSB:TCFG_INITVAL_LSB], 2'b00};
    endfunction

endpackage

// File: rtl/csr_int_sync.sv
// Multi-bit, multi-stage flop synchroniser for asynchronous level inputs.
// Each bit is synchronised independently; no cross-bit coherency is implied.
module csr_int_sync #(
    parameter int WIDTH  = 9,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] sync_reg;
    logic [STAGES-1:0][WIDTH-1:0] sync_next;

    // Each stage samples the stage before it; stage 0 samples the raw input.
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign sync_next[gi] = d;
            end else begin : g_rest
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    // Shift the synchroniser chain every cycle.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= sync_next;
        end
    end

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/csr_timer_intc.sv
// Countdown timer (TCFG/TVAL/TI), interrupt line synchronisation, ESTAT.IS
// assembly and a req/ack interrupt handshake towards the commit stage.
module csr_timer_intc
    import csr_timer_intc_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_MAX    = 4
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        tcfg_wen,
    input  logic [31:0] tcfg_wdata,
    input  logic        ticlr_wen,
    input  logic [31:0] ticlr_wdata,
    output logic [31:0] tcfg,
    output logic [31:0] tval,
    input  logic [1:0]  soft_is,
    input  logic [7:0]  hw_int,
    input  logic        ipi_int,
    input  logic [12:0] ecfg_lie,
    input  logic        crmd_ie,
    output logic [12:0] estat_is,
    output logic        int_req,
    input  logic        int_ack,
    output logic [12:0] int_pending
);

    localparam int              CW        = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CW-1:0]   HOLD_LAST = CW'(HOLD_MAX - 1);

    // ---------------- timer ----------------
    logic [31:0] tcfg_reg, tcfg_next;
    logic [31:0] tval_reg, tval_next;
    logic        ti_reg, ti_next;
    logic        stopped_reg, stopped_next;
    logic        expire;

    // Only bit 0 of TICLR has meaning; the rest is deliberately ignored.
    logic unused_ticlr;
    assign unused_ticlr = ^ticlr_wdata[31:1];

    // Timer next-state: a TCFG write overrides counting (and any expiry) this cycle.
    always_comb begin
        tcfg_next    = tcfg_reg;
        tval_next    = tval_reg;
        ti_next      = ti_reg;
        stopped_next = stopped_reg;
        expire       = 1'b0;
        if (tcfg_wen) begin
            tcfg_next = tcfg_wdata;
            if (tcfg_wdata[TCFG_EN]) begin
                tval_next    = tcfg_reload(tcfg_wdata);
                stopped_next = 1'b0;
            end
        end else if (tcfg_reg[TCFG_EN] && !stopped_reg) begin
            if (tval_reg != 32'd0) begin
                tval_next = tval_reg - 32'd1;
            end else begin
                expire = 1'b1;
                if (tcfg_reg[TCFG_PERIODIC]) begin
                    tval_next = tcfg_reload(tcfg_reg);
                end else begin
                    tval_next    = 32'hFFFF_FFFF;
                    stopped_next = 1'b1;
                end
            end
        end
        // Expiry beats a simultaneous clear so no tick is lost.
        if (expire) begin
            ti_next = 1'b1;
        end else if (ticlr_wen && ticlr_wdata[TICLR_CLR]) begin
            ti_next = 1'b0;
        end
    end

    // Timer state registers.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            tcfg_reg    <= '0;
            tval_reg    <= '0;
            ti_reg      <= 1'b0;
            stopped_reg <= 1'b0;
        end else begin
            tcfg_reg    <= tcfg_next;
            tval_reg    <= tval_next;
            ti_reg      <= ti_next;
            stopped_reg <= stopped_next;
        end
    end

    assign tcfg = tcfg_reg;
    assign tval = tval_reg;

    // ---------------- interrupt lines ----------------
    logic [8:0] sync_q;

    csr_int_sync #(
        .WIDTH  (9),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .aresetn (aresetn),
        .d       ({ipi_int, hw_int}),
        .q       (sync_q)
    );

    assign estat_is    = {sync_q[8], ti_reg, 1'b0, sync_q[7:0], soft_is};
    assign int_pending = estat_is & ecfg_lie;

    logic irq;
    assign irq = crmd_ie & (|int_pending);

    // ---------------- request handshake ----------------
    int_state_e    state_reg, state_next;
    logic [CW-1:0] hold_cnt_reg, hold_cnt_next;

    // Handshake next-state; HOLD masks the window before CRMD.IE falls on entry.
    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        int_req       = 1'b0;
        case (state_reg)
            INT_IDLE: begin
                if (irq) begin
                    state_next = INT_REQ;
                end
            end
            INT_REQ: begin
                int_req = 1'b1;
                if (int_ack) begin
                    state_next    = INT_HOLD;
                    hold_cnt_next = '0;
                end else if (!irq) begin
                    state_next = INT_IDLE;
                end
            end
            INT_HOLD: begin
                if (!crmd_ie || hold_cnt_reg == HOLD_LAST) begin
                    state_next = INT_IDLE;
                end else begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = INT_IDLE;
            end
        endcase
    end

    // Handshake state registers.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg    <= INT_IDLE;
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

endmodule

// File: tb/tb_csr_timer_intc.sv
// Directed bench for csr_timer_intc: timer modes, synchroniser latency,
// request handshake, HOLD timeout and asynchronous reset.
module tb_csr_timer_intc;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        tcfg_wen;
    logic [31:0] tcfg_wdata;
    logic        ticlr_wen;
    logic [31:0] ticlr_wdata;
    logic [31:0] tcfg;
    logic [31:0] tval;
    logic [1:0]  soft_is;
    logic [7:0]  hw_int;
    logic        ipi_int;
    logic [12:0] ecfg_lie;
    logic        crmd_ie;
    logic [12:0] estat_is;
    logic        int_req;
    logic        int_ack;
    logic [12:0] int_pending;

    int vectors     = 0;
    int miscompares = 0;

    csr_timer_intc #(
        .SYNC_STAGES (2),
        .HOLD_MAX    (4)
    ) dut (
        .clk         (clk),
        .aresetn     (aresetn),
        .tcfg_wen    (tcfg_wen),
        .tcfg_wdata  (tcfg_wdata),
        .ticlr_wen   (ticlr_wen),
        .ticlr_wdata (ticlr_wdata),
        .tcfg        (tcfg),
        .tval        (tval),
        .soft_is     (soft_is),
        .hw_int      (hw_int),
        .ipi_int     (ipi_int),
        .ecfg_lie    (ecfg_lie),
        .crmd_ie     (crmd_ie),
        .estat_is    (estat_is),
        .int_req     (int_req),
        .int_ack     (int_ack),
        .int_pending (int_pending)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("vec %0d %s observed=%h", vectors, tag, obs);
    endtask

    initial begin
        aresetn     = 1'b0;
        tcfg_wen    = 1'b0;
        tcfg_wdata  = '0;
        ticlr_wen   = 1'b0;
        ticlr_wdata = '0;
        soft_is     = 2'b10;
        hw_int      = '0;
        ipi_int     = 1'b0;
        ecfg_lie    = '0;
        crmd_ie     = 1'b0;
        int_ack     = 1'b0;

        // ---- reset state ----
        #2;
        check("rst_tcfg", tcfg, 32'h0);
        check("rst_tval", tval, 32'h0);
        check("rst_req", int_req, 1'b0);
        check("rst_estat", estat_is, 13'h002);
        tick();
        tick();
        aresetn = 1'b1;
        soft_is = 2'b00;
        tick();

        // ---- one-shot timer: InitVal=4 -> tval=16 ----
        tcfg_wen = 1'b1; tcfg_wdata = 32'h0000_0011;
        tick();
        tcfg_wen = 1'b0;
        check("os_tcfg", tcfg, 32'h0000_0011);
        check("os_load", tval, 32'd16);
        tick();
        check("os_dec1", tval, 32'd15);
        repeat (15) tick();
        check("os_zero", tval, 32'd0);
        check("os_ti_before", estat_is[11], 1'b0);
        tick();
        check("os_ti_set", estat_is[11], 1'b1);
        check("os_tval_ff", tval, 32'hFFFF_FFFF);
        ticlr_wen = 1'b1; ticlr_wdata = 32'h1;
        tick();
        ticlr_wen = 1'b0;
        check("os_ti_clr", estat_is[11], 1'b0);
        repeat (20) tick();
        check("os_no_2nd_ti", estat_is[11], 1'b0);
        check("os_tval_held", tval, 32'hFFFF_FFFF);

        // ---- periodic timer: InitVal=2 -> tval=8, expiry every 9 cycles ----
        tcfg_wen = 1'b1; tcfg_wdata = 32'h0000_000B;
        tick();                             // E0
        tcfg_wen = 1'b0;
        check("per_load", tval, 32'd8);
        repeat (8) tick();                  // E8
        check("per_zero", tval, 32'd0);
        check("per_ti_before", estat_is[11], 1'b0);
        ticlr_wen = 1'b1;
        tick();                             // E9: expiry beats clear
        check("per_ti_e9", estat_is[11], 1'b1);
        check("per_reload", tval, 32'd8);
        tick();                             // E10: clear alone
        ticlr_wen = 1'b0;
        check("per_ti_clr", estat_is[11], 1'b0);
        check("per_tval_e10", tval, 32'd7);
        repeat (7) tick();                  // E17
        check("per_ti_e17", estat_is[11], 1'b0);
        ticlr_wen = 1'b1;
        tick();                             // E18: expiry + clear same cycle
        ticlr_wen = 1'b0;
        check("per_ti_e18_set_wins", estat_is[11], 1'b1);
        check("per_reload2", tval, 32'd8);
        tick();                             // E19
        tick();                             // E20
        ticlr_wen = 1'b1;
        tick();                             // E21
        ticlr_wen = 1'b0;
        check("per_ti_clr3", estat_is[11], 1'b0);
        check("per_tval_e21", tval, 32'd5);
        tcfg_wen = 1'b1; tcfg_wdata = 32'h0;
        tick();                             // disable: tval holds
        tcfg_wen = 1'b0;
        check("dis_tval", tval, 32'd5);
        repeat (3) tick();
        check("dis_tval_held", tval, 32'd5);

        // ---- write during expiry: write wins ----
        tcfg_wen = 1'b1; tcfg_wdata = 32'h0000_0007;   // InitVal=1 -> 4, periodic
        tick();
        tcfg_wen = 1'b0;
        repeat (4) tick();
        check("ww_zero", tval, 32'd0);
        tcfg_wen = 1'b1; tcfg_wdata = 32'h0000_0013;   // InitVal=4 -> 16
        tick();
        check("ww_tval", tval, 32'd16);
        check("ww_no_ti", estat_is[11], 1'b0);
        tcfg_wdata = 32'h0;
        tick();
        tcfg_wen = 1'b0;

        // ---- hardware line through synchroniser ----
        ecfg_lie = 13'h0020;
        crmd_ie  = 1'b1;
        hw_int   = 8'h08;
        tick();
        check("hw_lat1", estat_is[5], 1'b0);
        tick();
        check("hw_lat2", estat_is[5], 1'b1);
        check("hw_pending", int_pending, 13'h0020);
        check("hw_req_early", int_req, 1'b0);
        tick();
        check("hw_req", int_req, 1'b1);

        // ---- handshake ----
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hs_hold_req", int_req, 1'b1);
        end
        int_ack = 1'b1;
        tick();                             // A: -> HOLD
        int_ack = 1'b0;
        check("hs_ack_drop", int_req, 1'b0);
        tick();                             // A+1
        crmd_ie = 1'b0;
        tick();                             // A+2: -> IDLE
        check("hs_hold_ie0", int_req, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hs_no_rereq", int_req, 1'b0);
        end
        crmd_ie = 1'b1;
        tick();
        check("hs_rereq", int_req, 1'b1);

        // ---- withdrawal ----
        ecfg_lie = 13'h0;
        tick();
        check("wd_drop", int_req, 1'b0);
        check("wd_pending", int_pending, 13'h0);
        ecfg_lie = 13'h0020;
        tick();
        check("wd_rereq", int_req, 1'b1);

        // ---- HOLD timeout with crmd_ie kept high ----
        int_ack = 1'b1;
        tick();                             // A: HOLD cnt 0
        int_ack = 1'b0;
        check("ht_ack", int_req, 1'b0);
        for (int i = 0; i < 4; i++) begin   // HOLD cnt 1..3, then IDLE
            tick();
            check("ht_hold", int_req, 1'b0);
        end
        tick();
        check("ht_rereq", int_req, 1'b1);

        // ---- InitVal=0 periodic: TI every cycle, set beats clear ----
        tcfg_wen = 1'b1; tcfg_wdata = 32'h0000_0003;
        tick();
        tcfg_wen = 1'b0;
        check("z_tval", tval, 32'd0);
        ticlr_wen = 1'b1; ticlr_wdata = 32'h1;
        tick();
        check("z_ti1", estat_is[11], 1'b1);
        tick();
        ticlr_wen = 1'b0;
        check("z_ti2", estat_is[11], 1'b1);

        // ---- asynchronous reset while in REQ with timer running ----
        tcfg_wen = 1'b1; tcfg_wdata = 32'h0000_0107;   // InitVal=65 -> 260
        tick();
        tcfg_wen = 1'b0;
        tick();
        check("ar_tval_run", tval, 32'd259);
        check("ar_req_pre", int_req, 1'b1);
        #2;
        aresetn = 1'b0;
        #1;
        check("ar_req", int_req, 1'b0);
        check("ar_tval", tval, 32'h0);
        check("ar_tcfg", tcfg, 32'h0);
        check("ar_estat", estat_is, 13'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
